// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the memory channel arbiter:
//   - arb_state_e  : arbiter FSM states (IDLE, CMD, RSP)
//   - PerfCntWidth : width of each per-requester grant counter
//   - Def*         : default parameter values for the arbiter top
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  localparam int PerfCntWidth = 16;

  localparam int DefNumReq    = 4;
  localparam int DefAddrWidth = 48;
  localparam int DefDataWidth = 512;
  localparam int DefLenWidth  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_RSP  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// ---------------------------------------------------------------------------
// mem_arb_rr_pick
// Purely combinational round-robin selector. Scans the request vector
// starting at ptr_i and wrapping modulo NumReq; the first set bit wins.
// Ports:
//   req_i   in  NumReq  request vector
//   ptr_i   in  IdxW    highest-priority index for this pick
//   idx_o   out IdxW    winning index (0 when nothing is requested)
//   valid_o out 1       at least one request present
// ---------------------------------------------------------------------------
module mem_arb_rr_pick #(
  parameter  int NumReq = 4,
  localparam int IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [IdxW-1:0]   idx_o,
  output logic              valid_o
);

  int cand;

  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    for (int i = 0; i < NumReq; i++) begin
      // ptr_i may exceed NumReq-1 only for non-power-of-two NumReq; the
      // modulo keeps the candidate in range either way.
      cand = (int'(ptr_i) + i) % NumReq;
      if (!valid_o && req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = IdxW'(cand);
      end
    end
  end

endmodule

// File: rtl/mem_channel_arbiter.sv
// ---------------------------------------------------------------------------
// mem_channel_arbiter
// Shares one memory channel among NumReq requesters. One transaction owns
// the channel at a time: IDLE picks a requester round-robin, CMD forwards
// the owner's command to memory, RSP routes response beats back to the
// owner until the memory marks the last beat.
//
// Handshake semantics (all valid/ready pairs): a transfer happens on a
// clock edge where valid and ready are both high. Valid, once raised, is
// expected to stay high with stable payload until the transfer; a requester
// dropping valid while it owns the channel in CMD abandons the transaction
// and is flagged as a protocol error. The response path has no ready: beats
// are accepted every cycle mem_rsp_valid_i is high.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   req_valid_i/req_ready_o      per-requester command handshake
//   req_write_i/addr/len/wdata   per-requester command payload (flattened)
//   rsp_valid_o                  response beat to the owner (one-hot)
//   rsp_rdata_o/rsp_last_o       broadcast response data / last flag
//   mem_cmd_*                    command towards the memory channel
//   mem_rsp_*                    responses from the memory channel
//   busy_o                       channel owned (CMD or RSP)
//   owner_o                      registered owner index
//   err_o                        sticky protocol error
//   perf_grants_o                per-requester 16-bit grant counters
//
// Build option: define MEM_ARB_PERF_CNT_EN to include saturating grant
// counters; without it perf_grants_o is tied to zero and no counter flops
// exist.
// ---------------------------------------------------------------------------
module mem_channel_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NumReq    = DefNumReq,
  parameter int AddrWidth = DefAddrWidth,
  parameter int DataWidth = DefDataWidth,
  parameter int LenWidth  = DefLenWidth
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NumReq-1:0]               req_valid_i,
  output logic [NumReq-1:0]               req_ready_o,
  input  logic [NumReq-1:0]               req_write_i,
  input  logic [NumReq*AddrWidth-1:0]     req_addr_i,
  input  logic [NumReq*LenWidth-1:0]      req_len_i,
  input  logic [NumReq*DataWidth-1:0]     req_wdata_i,
  output logic [NumReq-1:0]               rsp_valid_o,
  output logic [DataWidth-1:0]            rsp_rdata_o,
  output logic                            rsp_last_o,
  output logic                            mem_cmd_valid_o,
  input  logic                            mem_cmd_ready_i,
  output logic                            mem_write_o,
  output logic [AddrWidth-1:0]            mem_addr_o,
  output logic [LenWidth-1:0]             mem_len_o,
  output logic [DataWidth-1:0]            mem_wdata_o,
  input  logic                            mem_rsp_valid_i,
  input  logic [DataWidth-1:0]            mem_rsp_rdata_i,
  input  logic                            mem_rsp_last_i,
  output logic                            busy_o,
  output logic [$clog2(NumReq)-1:0]       owner_o,
  output logic                            err_o,
  output logic [NumReq*PerfCntWidth-1:0]  perf_grants_o
);

  localparam int IdxW = $clog2(NumReq);
  // One extra bit so len+1 beats (e.g. 256 for an 8-bit len) is representable.
  localparam int CntW = LenWidth + 1;

  arb_state_e      state_q, state_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [IdxW-1:0] rr_q, rr_d;
  logic            err_q, err_d;
  logic [CntW-1:0] beat_cnt_q, beat_cnt_d;
  logic [CntW-1:0] exp_beats_q, exp_beats_d;
  logic [CntW-1:0] beat_next;

  logic [IdxW-1:0] pick_idx;
  logic            pick_valid;

  logic                 own_valid;
  logic                 own_write;
  logic [AddrWidth-1:0] own_addr;
  logic [LenWidth-1:0]  own_len;
  logic [DataWidth-1:0] own_wdata;
  logic                 cmd_hs;

  mem_arb_rr_pick #(
    .NumReq (NumReq)
  ) u_rr_pick (
    .req_i   (req_valid_i),
    .ptr_i   (rr_q),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // Owner's command slice.
  assign own_valid = req_valid_i[owner_q];
  assign own_write = req_write_i[owner_q];
  assign own_addr  = req_addr_i[int'(owner_q)*AddrWidth +: AddrWidth];
  assign own_len   = req_len_i[int'(owner_q)*LenWidth +: LenWidth];
  assign own_wdata = req_wdata_i[int'(owner_q)*DataWidth +: DataWidth];

  assign cmd_hs = (state_q == ST_CMD) && own_valid && mem_cmd_ready_i;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_d        = rr_q;
    err_d       = err_q;
    beat_cnt_d  = beat_cnt_q;
    exp_beats_d = exp_beats_q;
    // Saturate so a runaway response stream cannot wrap back to a "legal"
    // count; err_o is already set long before saturation matters.
    beat_next   = (beat_cnt_q == '1) ? beat_cnt_q : beat_cnt_q + CntW'(1);

    case (state_q)
      ST_IDLE: begin
        if (mem_rsp_valid_i) err_d = 1'b1;
        if (pick_valid) begin
          owner_d = pick_idx;
          state_d = ST_CMD;
        end
      end

      ST_CMD: begin
        if (mem_rsp_valid_i) err_d = 1'b1;
        if (!own_valid) begin
          // Abandoned command: rr pointer is left alone so the same
          // requester keeps its priority when it asks again.
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (mem_cmd_ready_i) begin
          state_d     = ST_RSP;
          beat_cnt_d  = '0;
          // Writes carry a single beat and get a single acknowledge beat,
          // regardless of the len field.
          exp_beats_d = own_write ? CntW'(1) : ({1'b0, own_len} + CntW'(1));
        end
      end

      ST_RSP: begin
        if (mem_rsp_valid_i) begin
          beat_cnt_d = beat_next;
          if (mem_rsp_last_i) begin
            state_d = ST_IDLE;
            rr_d    = (owner_q == IdxW'(NumReq - 1)) ? '0 : owner_q + IdxW'(1);
            if (beat_next != exp_beats_q) err_d = 1'b1;
          end else if (beat_next >= exp_beats_q) begin
            // Expected count reached (or passed) without last: keep
            // draining until memory finally marks the last beat.
            err_d = 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      rr_q        <= '0;
      err_q       <= 1'b0;
      beat_cnt_q  <= '0;
      exp_beats_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_q        <= rr_d;
      err_q       <= err_d;
      beat_cnt_q  <= beat_cnt_d;
      exp_beats_q <= exp_beats_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: everything towards memory/requesters is zero unless the state
  // explicitly drives it, so IDLE (including right after reset) is quiet.
  // -------------------------------------------------------------------------
  always_comb begin
    req_ready_o     = '0;
    rsp_valid_o     = '0;
    rsp_rdata_o     = '0;
    rsp_last_o      = 1'b0;
    mem_cmd_valid_o = 1'b0;
    mem_write_o     = 1'b0;
    mem_addr_o      = '0;
    mem_len_o       = '0;
    mem_wdata_o     = '0;

    case (state_q)
      ST_CMD: begin
        mem_cmd_valid_o      = own_valid;
        mem_write_o          = own_write;
        mem_addr_o           = own_addr;
        mem_len_o            = own_len;
        mem_wdata_o          = own_wdata;
        req_ready_o[owner_q] = mem_cmd_ready_i;
      end
      ST_RSP: begin
        rsp_valid_o[owner_q] = mem_rsp_valid_i;
        rsp_rdata_o          = mem_rsp_rdata_i;
        rsp_last_o           = mem_rsp_last_i;
      end
      default: ;
    endcase
  end

  assign busy_o  = (state_q != ST_IDLE);
  assign owner_o = owner_q;
  assign err_o   = err_q;

  // -------------------------------------------------------------------------
  // Grant counters
  // -------------------------------------------------------------------------
`ifdef MEM_ARB_PERF_CNT_EN
  logic [NumReq-1:0][PerfCntWidth-1:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (cmd_hs && (perf_q[owner_q] != '1)) begin
      perf_d[owner_q] = perf_q[owner_q] + PerfCntWidth'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) perf_q <= '0;
    else       perf_q <= perf_d;
  end

  assign perf_grants_o = perf_q;
`else
  assign perf_grants_o = '0;
`endif

endmodule
